bcd_seq_addsub: RTL

Parametrised, sequential BCD adder/subtractor for the lab datapath. It processes two DIGITS-wide packed-BCD operands one digit per clock, least-significant digit first, with a start/busy/done handshake. It adds a subtract mode (ten's-complement), invalid-digit detection and per-digit active-low seven-segment outputs. It generalises the fixed two-digit combinational BCD adder and drives the board HEX displays directly.

---
 rtl/bcd_seq_addsub_if.sv | 28 ++
 rtl/bcd_seq_addsub.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bcd_seq_addsub_if.sv
// Operand/result bundle for the sequential BCD adder/subtractor.
// The master side issues requests; the slave side is the adder itself.
interface bcd_seq_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  op;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  neg;
  logic                  err;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output start, op, cin, a, b,
    input  busy, done, sum, cout, neg, err, seg
  );

  modport slave (
    input  start, op, cin, a, b,
    output busy, done, sum, cout, neg, err, seg
  );
endinterface

// File: rtl/bcd_seq_addsub.sv
// Digit-serial packed-BCD adder/subtractor, LSD first, one digit per clock.
// Also drives active-low seven-segment codes for every result digit.
module bcd_seq_addsub #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  bcd_seq_addsub_if.slave    bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_q, b_q, work, work_next, sum_q;
  logic          op_q, carry, err_pending, cout_q, neg_q, err_q;
  logic [IW-1:0] idx;
  logic [3:0]    a_k, b_k, bk, digit;
  logic [4:0]    t;
  logic          digit_carry, last, accept, bad_in;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) bad_in = 1'b1;
  end

  always_comb begin
    a_k       = 4'd0;
    b_k       = 4'd0;
    work_next = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        a_k                 = a_q[4*i +: 4];
        b_k                 = b_q[4*i +: 4];
        work_next[4*i +: 4] = digit;
      end
    end
  end

  // Subtraction adds the nine's complement of B with the carry preset to 1.
  assign bk          = op_q ? (4'd9 - b_k) : b_k;
  assign t           = {1'b0, a_k} + {1'b0, bk} + {4'd0, carry};
  assign digit_carry = (t > 5'd9);
  assign digit       = digit_carry ? (t[3:0] + 4'd6) : t[3:0];
  assign last        = (idx == IW'(DIGITS - 1));

  // Results are registered on the last RUN edge so they are already valid
  // during the DONE cycle, and then hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
      err_pending <= 1'b0;
      work        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      neg_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        a_q         <= bus.a;
        b_q         <= bus.b;
        op_q        <= bus.op;
        carry       <= bus.op | bus.cin;
        idx         <= '0;
        err_pending <= bad_in;
      end
      if (state == RUN) begin
        work  <= work_next;
        carry <= digit_carry;
        if (!last) idx <= idx + 1'b1;
        if (last) begin
          sum_q  <= err_pending ? '0 : work_next;
          cout_q <= ~err_pending & digit_carry;
          neg_q  <= ~err_pending & op_q & ~digit_carry;
          err_q  <= err_pending;
        end
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;

  always_comb begin
    bus.seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      case (sum_q[4*i +: 4])
        4'd0:    bus.seg[7*i +: 7] = 7'b1000000;
        4'd1:    bus.seg[7*i +: 7] = 7'b1111001;
        4'd2:    bus.seg[7*i +: 7] = 7'b0100100;
        4'd3:    bus.seg[7*i +: 7] = 7'b0110000;
        4'd4:    bus.seg[7*i +: 7] = 7'b0011001;
        4'd5:    bus.seg[7*i +: 7] = 7'b0010010;
        4'd6:    bus.seg[7*i +: 7] = 7'b0000010;
        4'd7:    bus.seg[7*i +: 7] = 7'b1111000;
        4'd8:    bus.seg[7*i +: 7] = 7'b0000000;
        4'd9:    bus.seg[7*i +: 7] = 7'b0010000;
        default: bus.seg[7*i +: 7] = 7'b1111111;
      endcase
    end
  end
endmodule
